// File: rtl/spu_pkg.sv
// -----------------------------------------------------------------------------
// spu_pkg
// Shared types for the odd-pipe result staging logic.
//   QUADWORD_W      : width of one register value (128 bits, big-endian [0:127])
//   REG_ADDR_W      : width of a register address (7 bits, [0:6])
//   staged_result_t : one in-flight result {valid, addr, data}
//   make_entry()    : builds a staged entry; non-writing results become all-zero
// -----------------------------------------------------------------------------
package spu_pkg;

  localparam int QUADWORD_W = 128;
  localparam int REG_ADDR_W = 7;

  typedef logic [0:QUADWORD_W-1] quadword_t;
  typedef logic [0:REG_ADDR_W-1] reg_addr_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    quadword_t data;
  } staged_result_t;

  localparam staged_result_t EMPTY_ENTRY = '0;

  // Bubbles carry no payload: address and data are zeroed so waveforms stay
  // clean and nothing downstream can mistake leftover data for a result.
  function automatic staged_result_t make_entry(input logic      en,
                                                input reg_addr_t addr,
                                                input quadword_t data);
    staged_result_t e;
    e = EMPTY_ENTRY;
    if (en) begin
      e.valid = 1'b1;
      e.addr  = addr;
      e.data  = data;
    end
    return e;
  endfunction

endpackage

// File: rtl/odd_wb_stage_if.sv
// -----------------------------------------------------------------------------
// odd_wb_stage_if
// Bundles the result input, the three forwarding lookup ports and the
// Register Table write port of the odd-pipe write-back stage.
//   in_*            : result from Local_Store plus branch_is_taken
//   fwd_addr_[abc]  : lookup addresses (ra, rb, store rc)
//   fwd_hit/data_*  : forwarded values
//   wb_*            : Register Table write port
//   pending_count   : number of valid in-flight results
// Modports: master drives inputs / lookups, slave is the staging pipe.
// -----------------------------------------------------------------------------
interface odd_wb_stage_if #(
  parameter int DEPTH = 7
);
  import spu_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  quadword_t        in_data;
  reg_addr_t        in_reg_addr;
  logic             in_enable_reg_write;
  logic             branch_is_taken;

  reg_addr_t        fwd_addr_a;
  reg_addr_t        fwd_addr_b;
  reg_addr_t        fwd_addr_c;
  quadword_t        fwd_data_a;
  quadword_t        fwd_data_b;
  quadword_t        fwd_data_c;
  logic             fwd_hit_a;
  logic             fwd_hit_b;
  logic             fwd_hit_c;

  quadword_t        wb_data;
  reg_addr_t        wb_reg_addr;
  logic             wb_enable_reg_write;
  logic [CNT_W-1:0] pending_count;

  modport master (
    output in_data, in_reg_addr, in_enable_reg_write, branch_is_taken,
    output fwd_addr_a, fwd_addr_b, fwd_addr_c,
    input  fwd_data_a, fwd_data_b, fwd_data_c,
    input  fwd_hit_a, fwd_hit_b, fwd_hit_c,
    input  wb_data, wb_reg_addr, wb_enable_reg_write, pending_count
  );

  modport slave (
    input  in_data, in_reg_addr, in_enable_reg_write, branch_is_taken,
    input  fwd_addr_a, fwd_addr_b, fwd_addr_c,
    output fwd_data_a, fwd_data_b, fwd_data_c,
    output fwd_hit_a, fwd_hit_b, fwd_hit_c,
    output wb_data, wb_reg_addr, wb_enable_reg_write, pending_count
  );

endinterface

// File: rtl/fwd_select.sv
// -----------------------------------------------------------------------------
// fwd_select
// One forwarding lookup port: searches all staged results for addr_i and
// returns the youngest (lowest index) valid match.
//   stages_i : staged results, index 0 youngest
//   addr_i   : source register address to look up
//   hit_o    : a valid staged result targets addr_i
//   data_o   : that result's value, 0 on miss
// -----------------------------------------------------------------------------
module fwd_select
  import spu_pkg::*;
#(
  parameter int DEPTH = 7
) (
  input  staged_result_t stages_i [DEPTH],
  input  reg_addr_t      addr_i,
  output logic           hit_o,
  output quadword_t      data_o
);

  logic [DEPTH-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = stages_i[gi].valid && (stages_i[gi].addr == addr_i);
    end
  endgenerate

  // Walk from oldest to youngest so the youngest match overwrites last.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit_o  = 1'b1;
        data_o = stages_i[i].data;
      end
    end
  end

endmodule

// File: rtl/odd_wb_stage.sv
// -----------------------------------------------------------------------------
// odd_wb_stage
// Result staging and forwarding pipe behind Local_Store in the odd pipe.
// Every cycle one result enters stage 0 and all stages shift one place; the
// oldest stage drives the Register Table write port. All staged results are
// visible on three forwarding ports. A taken branch invalidates the youngest
// FLUSH_DEPTH stages after the shift.
//   clock  : rising-edge clock
//   reset  : asynchronous active-low reset, clears every stage and the count
//   bus    : odd_wb_stage_if slave (inputs, forwarding, write-back, count)
// Parameters: DEPTH (2..8) staging stages, FLUSH_DEPTH (0..DEPTH-1).
// -----------------------------------------------------------------------------
module odd_wb_stage
  import spu_pkg::*;
#(
  parameter int DEPTH       = 7,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  odd_wb_stage_if.slave        bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  staged_result_t   stage_q [DEPTH];
  staged_result_t   stage_d [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next-state of each stage: shift, then apply the branch flush to the
  // youngest FLUSH_DEPTH post-shift positions (so with FLUSH_DEPTH=1 the
  // result captured on the branch edge is the one dropped).
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      staged_result_t shifted;

      if (gi == 0) begin : g_head
        assign shifted = make_entry(bus.in_enable_reg_write,
                                    bus.in_reg_addr,
                                    bus.in_data);
      end else begin : g_body
        assign shifted = stage_q[gi-1];
      end

      if (gi < FLUSH_DEPTH) begin : g_flush
        assign stage_d[gi] = bus.branch_is_taken ? EMPTY_ENTRY : shifted;
      end else begin : g_keep
        assign stage_d[gi] = shifted;
      end
    end
  endgenerate

  // Count is taken from the next-state so it always matches the registered
  // stage contents in the same cycle.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CNT_W'(stage_d[i].valid);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= EMPTY_ENTRY;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
      count_q <= count_d;
    end
  end

  // Write-back comes straight from the oldest stage.
  assign bus.wb_enable_reg_write = stage_q[DEPTH-1].valid;
  assign bus.wb_reg_addr         = stage_q[DEPTH-1].valid ? stage_q[DEPTH-1].addr : '0;
  assign bus.wb_data             = stage_q[DEPTH-1].valid ? stage_q[DEPTH-1].data : '0;
  assign bus.pending_count       = count_q;

  fwd_select #(.DEPTH(DEPTH)) u_fwd_a (
    .stages_i (stage_q),
    .addr_i   (bus.fwd_addr_a),
    .hit_o    (bus.fwd_hit_a),
    .data_o   (bus.fwd_data_a)
  );

  fwd_select #(.DEPTH(DEPTH)) u_fwd_b (
    .stages_i (stage_q),
    .addr_i   (bus.fwd_addr_b),
    .hit_o    (bus.fwd_hit_b),
    .data_o   (bus.fwd_data_b)
  );

  fwd_select #(.DEPTH(DEPTH)) u_fwd_c (
    .stages_i (stage_q),
    .addr_i   (bus.fwd_addr_c),
    .hit_o    (bus.fwd_hit_c),
    .data_o   (bus.fwd_data_c)
  );

endmodule

// File: tb/tb_odd_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_odd_wb_stage
// Directed bench for odd_wb_stage (DEPTH=7, FLUSH_DEPTH=1): reset state,
// single-result latency, forwarding priority, branch flush, bubbles, full
// pipe forwarding and asynchronous reset mid-stream.
// -----------------------------------------------------------------------------
module tb_odd_wb_stage;
  import spu_pkg::*;

  localparam int DEPTH = 7;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  odd_wb_stage_if #(.DEPTH(DEPTH)) bus ();

  odd_wb_stage #(.DEPTH(DEPTH), .FLUSH_DEPTH(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [6:0]   wb_addr_q [$];
  logic [127:0] wb_data_q [$];

  localparam logic [127:0] SINGLE_DATA = 128'hC39A50EB8FD64B12A7EFC3BBC39A50EB;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive(input logic en, input logic [6:0] addr,
                       input logic [127:0] data, input logic br);
    bus.in_enable_reg_write = en;
    bus.in_reg_addr         = addr;
    bus.in_data             = data;
    bus.branch_is_taken     = br;
    $display("drive en=%0b addr=%0d br=%0b data=%h", en, addr, br, data);
  endtask

  task automatic idle();
    bus.in_enable_reg_write = 1'b0;
    bus.in_reg_addr         = '0;
    bus.in_data             = '0;
    bus.branch_is_taken     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample_wb();
    if (bus.wb_enable_reg_write) begin
      wb_addr_q.push_back(bus.wb_reg_addr);
      wb_data_q.push_back(bus.wb_data);
    end
  endtask

  function automatic logic [127:0] tag_data(input int i);
    logic [31:0] w;
    w = 32'hA5A50000 | 32'(i);
    return {w, w, w, w};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int strobes;
    int exp_pend [5];
    logic [6:0] exp_addr [4];

    idle();
    bus.fwd_addr_a = '0;
    bus.fwd_addr_b = '0;
    bus.fwd_addr_c = '0;

    // Reset state
    #12;
    check("rst_wb_en",   128'(bus.wb_enable_reg_write), 128'd0);
    check("rst_wb_data", 128'(bus.wb_data),             128'd0);
    check("rst_pending", 128'(bus.pending_count),       128'd0);
    check("rst_hit_a",   128'(bus.fwd_hit_a),           128'd0);
    @(negedge clock);
    reset = 1'b1;

    // Single result: strobe exactly on the 7th sample, pending 1 for 7 cycles
    drive(1'b1, 7'd3, SINGLE_DATA, 1'b0);
    bus.fwd_addr_c = 7'd3;
    tick();
    idle();
    for (int k = 0; k <= 7; k++) begin
      check($sformatf("single_pend_%0d", k), 128'(bus.pending_count), (k < 7) ? 128'd1 : 128'd0);
      check($sformatf("single_wben_%0d", k), 128'(bus.wb_enable_reg_write), (k == 6) ? 128'd1 : 128'd0);
      check($sformatf("single_hitc_%0d", k), 128'(bus.fwd_hit_c), (k < 7) ? 128'd1 : 128'd0);
      if (k == 6) begin
        check("single_wb_addr", 128'(bus.wb_reg_addr), 128'd3);
        check("single_wb_data", 128'(bus.wb_data),     SINGLE_DATA);
      end
      if (k == 7) check("single_wb_data_idle", 128'(bus.wb_data), 128'd0);
      if (k < 7) tick();
    end
    bus.fwd_addr_c = '0;

    // Forward priority: youngest r5 wins
    drive(1'b1, 7'd5, 128'h1, 1'b0);
    tick();
    bus.fwd_addr_a = 7'd5;
    bus.fwd_addr_b = 7'd6;
    #1;
    check("fwd_first_data_a", 128'(bus.fwd_data_a), 128'h1);
    drive(1'b1, 7'd5, 128'h2, 1'b0);
    tick();
    idle();
    #1;
    check("fwd_hit_a",  128'(bus.fwd_hit_a),  128'd1);
    check("fwd_data_a", 128'(bus.fwd_data_a), 128'h2);
    check("fwd_hit_b",  128'(bus.fwd_hit_b),  128'd0);
    check("fwd_data_b", 128'(bus.fwd_data_b), 128'd0);
    repeat (8) tick();
    check("fwd_drained", 128'(bus.pending_count), 128'd0);

    // Flush: branch on the edge capturing r12
    wb_addr_q.delete();
    wb_data_q.delete();
    exp_pend = '{1, 2, 2, 3, 4};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 7'(10 + i), 128'(32'h100 + i), (i == 2));
      tick();
      check($sformatf("flush_pend_%0d", i), 128'(bus.pending_count), 128'(exp_pend[i]));
      sample_wb();
    end
    idle();
    repeat (10) begin
      tick();
      sample_wb();
    end
    exp_addr = '{7'd10, 7'd11, 7'd13, 7'd14};
    check("flush_retired", 128'(wb_addr_q.size()), 128'd4);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("flush_addr_%0d", j),
            (j < wb_addr_q.size()) ? 128'(wb_addr_q[j]) : '1, 128'(exp_addr[j]));
      check($sformatf("flush_data_%0d", j),
            (j < wb_data_q.size()) ? wb_data_q[j] : '1, 128'(32'h100 + 32'(exp_addr[j]) - 32'd10));
    end
    check("flush_drained", 128'(bus.pending_count), 128'd0);

    // Bubble behind one valid result: count unchanged, no hit, one strobe
    drive(1'b1, 7'd9, 128'h99, 1'b0);
    tick();
    drive(1'b0, 7'd3, '1, 1'b0);
    tick();
    idle();
    bus.fwd_addr_a = 7'd3;
    #1;
    check("bubble_pend",   128'(bus.pending_count), 128'd1);
    check("bubble_hit_a",  128'(bus.fwd_hit_a),     128'd0);
    check("bubble_data_a", 128'(bus.fwd_data_a),    128'd0);
    strobes = 0;
    wb_addr_q.delete();
    wb_data_q.delete();
    repeat (8) begin
      tick();
      if (bus.wb_enable_reg_write) strobes++;
      sample_wb();
    end
    check("bubble_strobes", 128'(strobes), 128'd1);
    check("bubble_wb_addr", (wb_addr_q.size() > 0) ? 128'(wb_addr_q[0]) : '1, 128'd9);

    // Full pipe: r1..r7
    for (int i = 1; i <= 7; i++) begin
      drive(1'b1, 7'(i), tag_data(i), 1'b0);
      tick();
    end
    idle();
    bus.fwd_addr_a = 7'd1;
    bus.fwd_addr_b = 7'd4;
    bus.fwd_addr_c = 7'd7;
    #1;
    check("full_pend",    128'(bus.pending_count),       128'd7);
    check("full_hit_a",   128'(bus.fwd_hit_a),           128'd1);
    check("full_hit_b",   128'(bus.fwd_hit_b),           128'd1);
    check("full_hit_c",   128'(bus.fwd_hit_c),           128'd1);
    check("full_data_a",  bus.fwd_data_a,                tag_data(1));
    check("full_data_b",  bus.fwd_data_b,                tag_data(4));
    check("full_data_c",  bus.fwd_data_c,                tag_data(7));
    check("full_wb_en",   128'(bus.wb_enable_reg_write), 128'd1);
    check("full_wb_addr", 128'(bus.wb_reg_addr),         128'd1);
    repeat (8) tick();
    bus.fwd_addr_b = '0;
    bus.fwd_addr_c = '0;

    // Asynchronous reset with four entries in flight
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 7'(20 + i), tag_data(20 + i), 1'b0);
      tick();
    end
    idle();
    bus.fwd_addr_a = 7'd20;
    #1;
    check("arst_pre_pend", 128'(bus.pending_count), 128'd4);
    check("arst_pre_hit",  128'(bus.fwd_hit_a),     128'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_wb_en",   128'(bus.wb_enable_reg_write), 128'd0);
    check("arst_wb_data", 128'(bus.wb_data),             128'd0);
    check("arst_pend",    128'(bus.pending_count),       128'd0);
    check("arst_hit_a",   128'(bus.fwd_hit_a),           128'd0);
    check("arst_data_a",  128'(bus.fwd_data_a),          128'd0);
    #2;
    reset = 1'b1;
    strobes = 0;
    repeat (10) begin
      tick();
      if (bus.wb_enable_reg_write) strobes++;
    end
    check("arst_no_stale_strobe", 128'(strobes), 128'd0);
    check("arst_post_pend",       128'(bus.pending_count), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/odd_wb_stage.md
Name: odd_wb_stage

Overview:
- Result staging and forwarding pipe directly downstream of Local_Store in the odd pipe.
- Accepts one 128-bit result per cycle (data, destination register, write enable) and carries it through DEPTH register stages before retiring it to the Register Table write port.
- While in flight, every staged result is visible to the Register File/Forwarding stage through three forwarding lookup ports (ra, rb, store operand).
- A taken branch squashes the younger in-flight results.

Parameters:
- DEPTH, 7, number of staging stages between result capture and write-back (legal range 2..8)
- FLUSH_DEPTH, 1, number of youngest stages invalidated on branch_is_taken (0..DEPTH-1)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_data  in  128 [0:127]  result from Local_Store (wb_data)
- in_reg_addr  in  7 [0:6]  destination register of in_data
- in_enable_reg_write  in  1  in_data is a register-writing result
- branch_is_taken  in  1  branch resolved taken this cycle
- fwd_addr_a, fwd_addr_b, fwd_addr_c  in  7 each  source register addresses (ra, rb, store rc)
- fwd_data_a, fwd_data_b, fwd_data_c  out  128 each  forwarded value
- fwd_hit_a, fwd_hit_b, fwd_hit_c  out  1 each  forwarded value valid
- wb_data  out  128  value written to Register Table
- wb_reg_addr  out  7  Register Table write address
- wb_enable_reg_write  out  1  Register Table write strobe
- pending_count  out  $clog2(DEPTH+1)  number of valid staged entries

Behaviour:
- Storage: stage[0..DEPTH-1], each holding {valid, addr[0:6], data[0:127]}. stage[0] is youngest.
- Reset (reset==0, async, any time including mid-stream):
  - all valid bits and addr/data clear to 0 immediately;
  - all outputs read 0 while reset is held: wb_*, fwd_*, pending_count.
  - No entry survives reset.
- Shift on every posedge; no stall input:
  - stage[i] <= stage[i-1] for i = 1..DEPTH-1;
  - stage[0] <= {in_enable_reg_write, in_reg_addr, in_data}.
- Entries with in_enable_reg_write==0 still shift as bubbles with valid=0. Their data is don't-care but must be forced to 0 for waveform clarity.
- Flush: when branch_is_taken==1 at a posedge, the post-shift stages 0..FLUSH_DEPTH-1 get valid=0.
  - With FLUSH_DEPTH=1 this drops the input captured that edge.
  - Older stages are unaffected.
  - Simultaneous branch_is_taken and valid input → input dropped.
  - FLUSH_DEPTH=0 disables flushing.
- Write-back: wb_* are driven directly from stage[DEPTH-1]; wb_enable_reg_write = stage[DEPTH-1].valid.
  - Latency: input captured at edge n appears on wb_* after edge n+DEPTH-1, i.e. DEPTH clock edges from in_* valid to Register Table write.
  - wb_data is 0 when not valid.
- Forwarding (combinational, each port independent):
  - Hit if any stage[i].valid && stage[i].addr == fwd_addr_x.
  - The lowest index (youngest) match wins; this includes stage[DEPTH-1], whose write coincides with the read.
  - On miss: fwd_hit_x = 0, fwd_data_x = 0.
  - The un-registered in_* values are never forwarded.
  - Address 0 is an ordinary register and forwards normally.
  - All three ports may hit the same entry in the same cycle.
- pending_count = popcount of valid bits, registered consistently with the stage contents (same cycle as stages). Range 0..DEPTH, no wrap.

Decomposition:
- Shared package (spu_pkg):
  - QUADWORD_W=128, REG_ADDR_W=7
  - typedef staged_result_t {valid, addr, data}
- One sub-module: fwd_select.
  - Parameterised on DEPTH.
  - Takes the stage array and one address; returns hit and data with youngest-priority.
  - Instantiated three times.

Test Plan:
- Single result: reset released, in_enable_reg_write=1, addr=3, data=128'hC39A50EB8FD64B12A7EFC3BBC39A50EB for one cycle → wb_enable_reg_write=1, wb_reg_addr=3, that data exactly DEPTH (7) edges later for one cycle; pending_count 1 for 7 cycles then 0.
- Forward priority: write r5=128'h1 then next cycle r5=128'h2; fwd_addr_a=5 → fwd_hit_a=1, fwd_data_a=128'h2. fwd_addr_b=6 → fwd_hit_b=0, data 0.
- Flush: stream r10..r14 valid back-to-back, branch_is_taken high on the edge capturing r12 → r12 never reaches wb; r10, r11, r13, r14 retire in order; pending_count dips accordingly.
- Bubble: in_enable_reg_write=0, addr=3, data=128'hFFFF… → no fwd hit on r3, no wb strobe, pending_count unchanged.
- Full pipe: 7 consecutive valid writes r1..r7 → pending_count=7; all three fwd ports (addr 1, 4, 7) hit simultaneously with correct data.
- Async reset mid-stream: pull reset low between edges with 4 entries pending → all outputs 0 immediately; after release no stale wb strobe ever appears.
